ping_pong_arbiter: RTL and testbench

PING_PONG_ARBITER -- requirements
Module: ping_pong_arbiter

---
 rtl/ping_pong_arbiter_if.sv | 27 ++
 rtl/ping_pong_arbiter.sv | 115 +++++++++++
 tb/tb_ping_pong_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ping_pong_arbiter_if.sv
// Bundle between the ping-pong arbiter, its two requesters and the shared
// ping-pong counter. The arbiter takes the slave view; the environment
// (requesters plus counter) takes the master view.
interface ping_pong_arbiter_if #(
    parameter int CNT_W = 4,
    parameter int BNC_W = 4
);
    logic [1:0]       req;
    logic [BNC_W-1:0] bounces_0;
    logic [BNC_W-1:0] bounces_1;
    logic [1:0]       grant;
    logic [1:0]       done;
    logic             busy;
    logic             cnt_enable;
    logic [CNT_W-1:0] cnt_out;
    logic             cnt_direction;

    modport slave (
        input  req, bounces_0, bounces_1, cnt_out, cnt_direction,
        output grant, done, busy, cnt_enable
    );

    modport master (
        output req, bounces_0, bounces_1, cnt_out, cnt_direction,
        input  grant, done, busy, cnt_enable
    );
endinterface

// File: rtl/ping_pong_arbiter.sv
// Round-robin arbiter for a shared ping-pong counter. The winner asks for a
// number of direction reversals ("bounces"); the arbiter enables the counter
// until that many reversals have been seen, then pulses done to the owner.
// All outputs are decoded from registered state (Moore machine).
module ping_pong_arbiter #(
    parameter int CNT_W = 4,
    parameter int BNC_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    ping_pong_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             owner, owner_nxt;      // requester holding the counter
    logic             last, last_nxt;        // requester served most recently
    logic [BNC_W-1:0] remaining, remaining_nxt;
    logic             dir_q, dir_q_nxt;      // direction seen at last count
    logic             pick;
    logic [BNC_W-1:0] pick_cnt;
    logic [1:0]       owner_oh;

    // On contention the requester not served last wins; otherwise whoever asks.
    assign pick     = (bus.req == 2'b11) ? ~last : bus.req[1];
    assign pick_cnt = pick ? bus.bounces_1 : bus.bounces_0;
    assign owner_oh = owner ? 2'b10 : 2'b01;

    // State and service bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            remaining <= '0;
            dir_q     <= 1'b1;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            last      <= last_nxt;
            remaining <= remaining_nxt;
            dir_q     <= dir_q_nxt;
        end
    end

    // Next-state: arbitrate in IDLE, count reversals in RUN, one-cycle DONE.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        last_nxt      = last;
        remaining_nxt = remaining;
        dir_q_nxt     = dir_q;
        case (state)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    owner_nxt     = pick;
                    last_nxt      = pick;
                    remaining_nxt = pick_cnt;
                    dir_q_nxt     = bus.cnt_direction;
                    state_nxt     = (pick_cnt == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!bus.req[owner]) begin
                    // Owner withdrew: release without completion.
                    state_nxt = IDLE;
                    last_nxt  = owner;
                end else if (bus.cnt_direction != dir_q) begin
                    dir_q_nxt = bus.cnt_direction;
                    if (remaining != '0) begin
                        remaining_nxt = remaining - BNC_W'(1);
                    end
                    if (remaining <= BNC_W'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode from the registered state and owner.
    always_comb begin
        bus.grant      = 2'b00;
        bus.done       = 2'b00;
        bus.busy       = 1'b0;
        bus.cnt_enable = 1'b0;
        case (state)
            RUN: begin
                bus.grant      = owner_oh;
                bus.busy       = 1'b1;
                bus.cnt_enable = 1'b1;
            end
            DONE: begin
                bus.grant = owner_oh;
                bus.done  = owner_oh;
                bus.busy  = 1'b1;
            end
            default: begin
                bus.grant = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_ping_pong_arbiter.sv
// Bench for ping_pong_arbiter: models the shared 4-bit ping-pong counter,
// queues the expected completion of each service when it is requested and
// compares against each done pulse.
module tb_ping_pong_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    ping_pong_arbiter_if #(.CNT_W(4), .BNC_W(4)) bus ();

    ping_pong_arbiter #(.CNT_W(4), .BNC_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Ping-pong counter: 0..15..0, reversing at the ends.
    logic [3:0] cq;
    logic       cd;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cq <= 4'd0;
            cd <= 1'b1;
        end else if (bus.cnt_enable) begin
            if (cd) begin
                if (cq == 4'd15) begin
                    cd <= 1'b0;
                    cq <= cq - 4'd1;
                end else begin
                    cq <= cq + 4'd1;
                end
            end else begin
                if (cq == 4'd0) begin
                    cd <= 1'b1;
                    cq <= cq + 4'd1;
                end else begin
                    cq <= cq - 4'd1;
                end
            end
        end
    end
    assign bus.cnt_out       = cq;
    assign bus.cnt_direction = cd;

    typedef struct {
        logic [1:0] done;
        int         flips;
        int         en;      // -1: enable cycles not checked
        bit         chk_cnt;
        int         out;
        int         dir;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   flips    = 0;
    int   en_cnt   = 0;
    logic prev_dir = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] d, input int f, input int en,
                            input bit cc, input int o, input int dr);
        exp_t e;
        e.done = d; e.flips = f; e.en = en; e.chk_cnt = cc; e.out = o; e.dir = dr;
        sb.push_back(e);
    endtask

    // Wait until every queued service has completed, then withdraw requests.
    task automatic wait_drain(input int max_cyc);
        int k;
        k = 0;
        while (sb.size() != 0 && k < max_cyc) begin
            @(negedge clk); #1;
            k++;
        end
        check("drain_timeout", sb.size(), 0);
        bus.req = 2'b00;
    endtask

    task automatic wait_grant(input int max_cyc);
        int k;
        k = 0;
        while (bus.grant == 2'b00 && k < max_cyc) begin
            @(posedge clk); #1;
            k++;
        end
        check("grant_timeout", (bus.grant != 2'b00), 1);
    endtask

    // Monitor: count reversals and enable cycles per service, score done pulses.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || bus.grant == 2'b00) begin
            flips  = 0;
            en_cnt = 0;
        end else begin
            if (bus.cnt_enable) en_cnt++;
            if (bus.cnt_direction != prev_dir) flips++;
        end
        prev_dir = bus.cnt_direction;
        if (bus.done != 2'b00) begin
            if (sb.size() == 0) begin
                check("unexpected_done", bus.done, 0);
            end else begin
                e = sb.pop_front();
                check("done_owner", bus.done, e.done);
                check("flip_count", flips, e.flips);
                if (e.en >= 0) check("enable_cycles", en_cnt, e.en);
                if (e.chk_cnt) begin
                    check("cnt_out_at_done", bus.cnt_out, e.out);
                    check("cnt_dir_at_done", bus.cnt_direction, e.dir);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] snap;
        bus.req = 2'b00;
        bus.bounces_0 = 4'd0;
        bus.bounces_1 = 4'd0;

        // Asynchronous reset state.
        #3 rst_n = 1'b0;
        #1;
        check("rst_grant", bus.grant, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cnt_enable", bus.cnt_enable, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // One bounce from a fresh counter: 17 enabled cycles, ends at 13 going down.
        bus.bounces_0 = 4'd1;
        push_exp(2'b01, 1, 17, 1'b1, 13, 0);
        bus.req = 2'b01;
        @(posedge clk); #1;
        check("grant_req0", bus.grant, 2'b01);
        check("run_enable", bus.cnt_enable, 1);
        wait_drain(100);
        @(posedge clk); #1;
        check("grant_drop", bus.grant, 0);

        // Both requesting with zero counts from reset: alternating DONE-only services.
        @(negedge clk);
        rst_n = 1'b0;
        bus.req = 2'b11;
        bus.bounces_0 = 4'd0;
        bus.bounces_1 = 4'd0;
        push_exp(2'b01, 0, 0, 1'b0, 0, 0);
        push_exp(2'b10, 0, 0, 1'b0, 0, 0);
        push_exp(2'b01, 0, 0, 1'b0, 0, 0);
        push_exp(2'b10, 0, 0, 1'b0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_arb_busy", bus.busy, 1);
        check("first_arb_enable", bus.cnt_enable, 0);
        wait_drain(40);

        // Abort after 20 RUN cycles: silent return to IDLE, counter frozen.
        @(negedge clk);
        bus.bounces_0 = 4'd3;
        bus.req = 2'b01;
        wait_grant(10);
        repeat (20) @(negedge clk);
        bus.req = 2'b00;
        @(posedge clk); #1;
        check("abort_grant", bus.grant, 0);
        check("abort_enable", bus.cnt_enable, 0);
        check("abort_busy", bus.busy, 0);
        snap = bus.cnt_out;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", bus.done, 0);
            check("abort_cnt_hold", bus.cnt_out, snap);
        end

        // The aborted owner counts as last served: requester 1 wins next.
        bus.bounces_0 = 4'd0;
        bus.bounces_1 = 4'd0;
        push_exp(2'b10, 0, 0, 1'b0, 0, 0);
        push_exp(2'b01, 0, 0, 1'b0, 0, 0);
        bus.req = 2'b11;
        wait_drain(20);

        // Reset mid-RUN, off the clock edge.
        @(negedge clk);
        bus.bounces_0 = 4'd5;
        bus.req = 2'b01;
        wait_grant(10);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        bus.req = 2'b00;
        #1;
        check("midrst_enable", bus.cnt_enable, 0);
        check("midrst_grant", bus.grant, 0);
        check("midrst_busy", bus.busy, 0);
        #2;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("postrst_no_done", bus.done, 0);
            check("postrst_idle", bus.busy, 0);
        end
        bus.bounces_0 = 4'd0;
        bus.bounces_1 = 4'd0;
        push_exp(2'b01, 0, 0, 1'b0, 0, 0);
        push_exp(2'b10, 0, 0, 1'b0, 0, 0);
        bus.req = 2'b11;
        wait_drain(20);

        // Bounce count changed after grant is ignored.
        @(negedge clk);
        bus.bounces_0 = 4'd2;
        push_exp(2'b01, 2, -1, 1'b0, 0, 0);
        bus.req = 2'b01;
        @(posedge clk); #1;
        check("grant_late_change", bus.grant, 2'b01);
        @(negedge clk);
        bus.bounces_0 = 4'd9;
        wait_drain(200);
        @(posedge clk); #1;
        check("late_change_idle", bus.grant, 0);

        // Maximum bounce count on requester 1.
        @(negedge clk);
        bus.bounces_1 = 4'd15;
        push_exp(2'b10, 15, -1, 1'b0, 0, 0);
        bus.req = 2'b10;
        wait_drain(400);
        repeat (3) @(negedge clk);
        check("final_idle", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
